// File: rtl/pc_ras_unit.sv
// pc_ras_unit: fetch-stage program counter with a circular return-address stack.
// PC select modes: hold, increment, relative branch, absolute jump, call and return.
// Calls push PC+1 and returns pop it. A full stack overwrites its oldest entry.
// Stack overflow and underflow set sticky flags; reserved select codes set
// ill_ps_out for the following cycle.
// Optional feature macro PC_TRACE_EN adds two outputs: pc_prev_out and redir_out.
module pc_ras_unit #(
  parameter int              AW        = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [AW-1:0]   RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall_in,
  input  logic [2:0]                       ps_in,
  input  logic [15:0]                      ins_in,
  input  logic [AW-1:0]                    ra_in,
  output logic [AW-1:0]                    pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt_out,
  output logic                             ras_ovf_out,
  output logic                             ras_unf_out,
`ifdef PC_TRACE_EN
  output logic [AW-1:0]                    pc_prev_out,
  output logic                             redir_out,
`endif
  output logic                             ill_ps_out
);

  localparam int CW = $clog2(RAS_DEPTH+1);
  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [2:0] PS_HOLD = 3'd0;
  localparam logic [2:0] PS_INC  = 3'd1;
  localparam logic [2:0] PS_BR   = 3'd2;
  localparam logic [2:0] PS_JMP  = 3'd3;
  localparam logic [2:0] PS_CALL = 3'd4;
  localparam logic [2:0] PS_RET  = 3'd5;

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] pc_inc;
  logic [5:0]    br_off;
  logic [AW-1:0] br_ext;
  logic          ras_full;
  logic          ras_empty;
  logic          push;
  logic          unused_ins;

  // Only the split offset field of the instruction is used here.
  assign unused_ins = ^{ins_in[15:9], ins_in[5:3]};

  assign rd_ptr    = wr_ptr - PW'(1);
  assign pc_inc    = pc_out + AW'(1);
  assign br_off    = {ins_in[8:6], ins_in[2:0]};
  assign br_ext    = {{(AW-6){br_off[5]}}, br_off};
  assign ras_full  = (ras_cnt_out == CW'(RAS_DEPTH));
  assign ras_empty = (ras_cnt_out == '0);
  assign push      = !stall_in && (ps_in == PS_CALL);

  // Stack storage carries no reset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (rst_n && push) ras_mem[wr_ptr] <= pc_inc;
  end

  // PC, stack pointer/count, sticky flags and trace registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out      <= RESET_PC;
      wr_ptr      <= '0;
      ras_cnt_out <= '0;
      ras_ovf_out <= 1'b0;
      ras_unf_out <= 1'b0;
      ill_ps_out  <= 1'b0;
`ifdef PC_TRACE_EN
      pc_prev_out <= RESET_PC;
      redir_out   <= 1'b0;
`endif
    end else if (!stall_in) begin
      ill_ps_out <= 1'b0;
`ifdef PC_TRACE_EN
      pc_prev_out <= pc_out;
      redir_out   <= 1'b0;
`endif
      case (ps_in)
        PS_HOLD: ;
        PS_INC: pc_out <= pc_inc;
        PS_BR: begin
          pc_out <= pc_out + br_ext;
`ifdef PC_TRACE_EN
          redir_out <= 1'b1;
`endif
        end
        PS_JMP: begin
          pc_out <= ra_in;
`ifdef PC_TRACE_EN
          redir_out <= 1'b1;
`endif
        end
        PS_CALL: begin
          pc_out <= ra_in;
          wr_ptr <= wr_ptr + PW'(1);
          // A full stack keeps its count; the push lands on the oldest slot.
          if (ras_full) ras_ovf_out <= 1'b1;
          else          ras_cnt_out <= ras_cnt_out + CW'(1);
`ifdef PC_TRACE_EN
          redir_out <= 1'b1;
`endif
        end
        PS_RET: begin
          if (ras_empty) begin
            pc_out      <= pc_inc;
            ras_unf_out <= 1'b1;
          end else begin
            pc_out      <= ras_mem[rd_ptr];
            wr_ptr      <= rd_ptr;
            ras_cnt_out <= ras_cnt_out - CW'(1);
`ifdef PC_TRACE_EN
            redir_out <= 1'b1;
`endif
          end
        end
        default: begin
          pc_out     <= pc_inc;
          ill_ps_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ras_unit.sv
module tb_pc_ras_unit;

  localparam int AW = 16;
  localparam int DEPTH = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic [2:0]  ps_in = 3'd0;
  logic [15:0] ins_in = 16'd0;
  logic [15:0] ra_in = 16'd0;
  logic [15:0] pc_out;
  logic [2:0]  ras_cnt_out;
  logic        ras_ovf_out, ras_unf_out, ill_ps_out;
`ifdef PC_TRACE_EN
  logic [15:0] pc_prev_out;
  logic        redir_out;
`endif

  pc_ras_unit #(.AW(AW), .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .ps_in(ps_in),
    .ins_in(ins_in), .ra_in(ra_in), .pc_out(pc_out), .ras_cnt_out(ras_cnt_out),
    .ras_ovf_out(ras_ovf_out), .ras_unf_out(ras_unf_out),
`ifdef PC_TRACE_EN
    .pc_prev_out(pc_prev_out), .redir_out(redir_out),
`endif
    .ill_ps_out(ill_ps_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a bounded list of return addresses, newest at the back.
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  bit          m_ovf, m_unf, m_ill;
  logic [15:0] m_prev;
  bit          m_redir;

  task automatic model_reset();
    m_pc = RST_PC; m_stack.delete(); m_ovf = 0; m_unf = 0; m_ill = 0;
    m_prev = RST_PC; m_redir = 0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [2:0] ps, input logic [15:0] ins,
                      input logic [15:0] ra, input bit stall);
    int off;
    stall_in = stall; ps_in = ps; ins_in = ins; ra_in = ra;
    if (!stall) begin
      m_ill = 0; m_prev = m_pc; m_redir = 0;
      case (ps)
        3'd0: ;
        3'd1: m_pc = m_pc + 16'd1;
        3'd2: begin
          off = int'({ins[8:6], ins[2:0]});
          if (off >= 32) off = off - 64;
          m_pc = 16'(int'(m_pc) + off);
          m_redir = 1;
        end
        3'd3: begin m_pc = ra; m_redir = 1; end
        3'd4: begin
          m_stack.push_back(m_pc + 16'd1);
          if (m_stack.size() > DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1;
          end
          m_pc = ra; m_redir = 1;
        end
        3'd5: begin
          if (m_stack.size() > 0) begin m_pc = m_stack.pop_back(); m_redir = 1; end
          else begin m_pc = m_pc + 16'd1; m_unf = 1; end
        end
        default: begin m_pc = m_pc + 16'd1; m_ill = 1; end
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; stall_in = 0; ps_in = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, RST_PC); end
    checks++; if (ras_cnt_out !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", ras_cnt_out); end
    checks++; if (ras_ovf_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ras_ovf_out); end
    checks++; if (ras_unf_out !== 1'b0) begin errors++; $display("FAIL reset_unf got %b exp 0", ras_unf_out); end
    checks++; if (ill_ps_out !== 1'b0) begin errors++; $display("FAIL reset_ill got %b exp 0", ill_ps_out); end
  endtask

  task automatic test_increment();
    for (int i = 0; i < 3; i++) begin
      step(3'd1, 16'd0, 16'd0, 0);
      checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL inc_pc[%0d] got %h exp %h", i, pc_out, m_pc); end
    end
    step(3'd3, 16'd0, 16'hFFFF, 0);
    step(3'd1, 16'd0, 16'd0, 0);
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL inc_wrap got %h exp 0000", pc_out); end
    step(3'd0, 16'd0, 16'h1234, 0);
    checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL hold_pc got %h exp %h", pc_out, m_pc); end
  endtask

  task automatic test_branch();
    logic [15:0] ins;
    step(3'd3, 16'd0, 16'h0010, 0);
    step(3'd2, 16'h01C6, 16'd0, 0);
    checks++; if (pc_out !== 16'h000E) begin errors++; $display("FAIL branch_neg2 got %h exp 000E", pc_out); end
    for (int i = 0; i < 8; i++) begin
      ins = 16'($urandom);
      step(3'd2, ins, 16'd0, 0);
      checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL branch_rand[%0d] ins %h got %h exp %h", i, ins, pc_out, m_pc); end
    end
  endtask

  task automatic test_call_return();
    step(3'd3, 16'd0, 16'h0020, 0);
    step(3'd4, 16'd0, 16'h0100, 0);
    checks++; if (pc_out !== 16'h0100 || ras_cnt_out !== 3'd1) begin errors++; $display("FAIL call got pc %h cnt %0d exp 0100/1", pc_out, ras_cnt_out); end
    step(3'd5, 16'd0, 16'd0, 0);
    checks++; if (pc_out !== 16'h0021 || ras_cnt_out !== 3'd0) begin errors++; $display("FAIL return got pc %h cnt %0d exp 0021/0", pc_out, ras_cnt_out); end
  endtask

  task automatic test_overflow_underflow();
    logic [15:0] exp_ret [4];
    exp_ret[0] = 16'h0051; exp_ret[1] = 16'h0041; exp_ret[2] = 16'h0031; exp_ret[3] = 16'h0021;
    step(3'd3, 16'd0, 16'h0010, 0);
    for (int k = 1; k <= 5; k++) step(3'd4, 16'd0, 16'((k + 1) * 16), 0);
    checks++; if (ras_ovf_out !== 1'b1 || ras_cnt_out !== 3'd4) begin errors++; $display("FAIL ovf got ovf %b cnt %0d exp 1/4", ras_ovf_out, ras_cnt_out); end
    for (int k = 0; k < 4; k++) begin
      step(3'd5, 16'd0, 16'd0, 0);
      checks++; if (pc_out !== exp_ret[k] || pc_out !== m_pc) begin errors++; $display("FAIL ret_nested[%0d] got %h exp %h", k, pc_out, exp_ret[k]); end
    end
    step(3'd5, 16'd0, 16'd0, 0);
    checks++; if (pc_out !== 16'h0022 || ras_unf_out !== 1'b1 || ras_cnt_out !== 3'd0) begin errors++; $display("FAIL unf got pc %h unf %b cnt %0d exp 0022/1/0", pc_out, ras_unf_out, ras_cnt_out); end
  endtask

  task automatic test_stall();
    logic [15:0] pc0;
    logic [2:0]  cnt0;
    pc0 = pc_out; cnt0 = ras_cnt_out;
    for (int i = 0; i < 3; i++) begin
      step(3'd4, 16'd0, 16'h0200, 1);
      checks++; if (pc_out !== pc0 || ras_cnt_out !== cnt0) begin errors++; $display("FAIL stall[%0d] got pc %h cnt %0d exp %h/%0d", i, pc_out, ras_cnt_out, pc0, cnt0); end
    end
    step(3'd4, 16'd0, 16'h0200, 0);
    checks++; if (pc_out !== 16'h0200 || ras_cnt_out !== cnt0 + 3'd1) begin errors++; $display("FAIL stall_release got pc %h cnt %0d exp 0200/%0d", pc_out, ras_cnt_out, cnt0 + 3'd1); end
  endtask

  task automatic test_illegal();
    logic [15:0] pc0;
    pc0 = pc_out;
    step(3'd6, 16'd0, 16'd0, 0);
    checks++; if (pc_out !== pc0 + 16'd1 || ill_ps_out !== 1'b1) begin errors++; $display("FAIL ill6 got pc %h ill %b exp %h/1", pc_out, ill_ps_out, pc0 + 16'd1); end
    step(3'd1, 16'd0, 16'd0, 1);
    checks++; if (ill_ps_out !== 1'b1) begin errors++; $display("FAIL ill_stall_hold got %b exp 1", ill_ps_out); end
    step(3'd1, 16'd0, 16'd0, 0);
    checks++; if (ill_ps_out !== 1'b0) begin errors++; $display("FAIL ill_clear got %b exp 0", ill_ps_out); end
    step(3'd7, 16'd0, 16'd0, 0);
    checks++; if (ill_ps_out !== 1'b1 || pc_out !== m_pc) begin errors++; $display("FAIL ill7 got pc %h ill %b exp %h/1", pc_out, ill_ps_out, m_pc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra;
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      step(3'd4, 16'd0, ra, 0);
      step(3'd5, 16'd0, 16'd0, 0);
      checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL b2b[%0d] got %h exp %h", i, pc_out, m_pc); end
    end
  endtask

  task automatic test_random();
    logic [2:0] ps;
    bit stall;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ps = 3'($urandom_range(0, 7));
      if (ps > 5 && $urandom_range(0, 3) != 0) ps = 3'($urandom_range(4, 5));
      stall = ($urandom_range(0, 4) == 0);
      step(ps, 16'($urandom), 16'($urandom), stall);
      checks++;
      if (pc_out !== m_pc || ras_cnt_out !== 3'(m_stack.size()) || ras_ovf_out !== m_ovf ||
          ras_unf_out !== m_unf || ill_ps_out !== m_ill) begin
        errors++;
        $display("FAIL rand[%0d] ps %0d stall %0d got pc %h cnt %0d ovf %b unf %b ill %b exp %h %0d %b %b %b",
                 i, ps, stall, pc_out, ras_cnt_out, ras_ovf_out, ras_unf_out, ill_ps_out,
                 m_pc, m_stack.size(), m_ovf, m_unf, m_ill);
      end
`ifdef PC_TRACE_EN
      checks++;
      if (pc_prev_out !== m_prev || redir_out !== m_redir) begin
        errors++;
        $display("FAIL trace[%0d] got prev %h redir %b exp %h %b", i, pc_prev_out, redir_out, m_prev, m_redir);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    step(3'd4, 16'd0, 16'h0300, 0);
    step(3'd6, 16'd0, 16'd0, 0);
    ps_in = 3'd4; ra_in = 16'h0400;
    #2 rst_n = 0;
    #1;
    checks++;
    if (pc_out !== RST_PC || ras_cnt_out !== 3'd0 || ras_ovf_out !== 1'b0 ||
        ras_unf_out !== 1'b0 || ill_ps_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got pc %h cnt %0d ovf %b unf %b ill %b exp %h 0 0 0 0",
               pc_out, ras_cnt_out, ras_ovf_out, ras_unf_out, ill_ps_out, RST_PC);
    end
    @(posedge clk); #1;
    checks++; if (pc_out !== RST_PC || ras_cnt_out !== 3'd0) begin errors++; $display("FAIL reset_held got pc %h cnt %0d", pc_out, ras_cnt_out); end
    rst_n = 1;
    model_reset();
    step(3'd5, 16'd0, 16'd0, 0);
    checks++; if (pc_out !== RST_PC + 16'd1 || ras_unf_out !== 1'b1) begin errors++; $display("FAIL post_reset_ret got pc %h unf %b exp %h/1", pc_out, ras_unf_out, RST_PC + 16'd1); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_increment();
    test_branch();
    test_call_return();
    test_overflow_underflow();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
